spi_frame_tx: RTL and testbench

SPI_FRAME_TX -- requirements
Module: spi_frame_tx

---
 rtl/spi_frame_tx.sv | 112 +++++++++++
 tb/tb_spi_frame_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_tx.sv
// LSB-first 11-bit frame serializer with a one-word holding register.
// Frames run back-to-back while enabled; IDLE_WORD fills a boundary with no data.
module spi_frame_tx #(
    parameter logic [10:0] IDLE_WORD = 11'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [10:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic [3:0]  bit_idx,
    output logic [5:0]  frame_count,
    output logic        underrun
);

    localparam int unsigned WORD_W   = 11;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned CNT_W    = 6;
    localparam int unsigned LAST_BIT = WORD_W - 1;

    typedef enum logic {
        S_OFF = 1'b0,
        S_RUN = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_shift;
    logic [WORD_W-1:0]   r_hold;
    logic                r_hold_full;
    logic [IDX_W-1:0]    r_bit_idx;
    logic [CNT_W-1:0]    r_frame_count;
    logic                r_underrun;

    logic                w_accept;
    logic                w_frame_end;
    logic                w_load;

    assign w_accept = in_valid && !r_hold_full;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and load/frame-end decode
    always_comb begin
        w_state_nxt = r_state;
        w_frame_end = (r_state == S_RUN) && (r_bit_idx == IDX_W'(LAST_BIT));
        w_load      = ((r_state == S_OFF) || w_frame_end) && en;
        case (r_state)
            S_OFF: if (en) w_state_nxt = S_RUN;
            S_RUN: if (w_frame_end && !en) w_state_nxt = S_OFF;
            default: w_state_nxt = S_OFF;
        endcase
    end

    // Datapath: shift/hold registers, bit index, frame counter, underrun pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift       <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_bit_idx     <= '0;
            r_frame_count <= CNT_W'(63);
            r_underrun    <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_load) begin
                r_bit_idx <= '0;
                // Held word first, then same-edge bypass, else idle fill
                if (r_hold_full) begin
                    r_shift     <= r_hold;
                    r_hold_full <= 1'b0;
                end else if (w_accept) begin
                    r_shift <= in_data;
                end else begin
                    r_shift    <= IDLE_WORD;
                    r_underrun <= 1'b1;
                end
            end else begin
                if (w_accept) begin
                    r_hold      <= in_data;
                    r_hold_full <= 1'b1;
                end
                if (w_frame_end) begin
                    r_shift   <= '0;
                    r_bit_idx <= '0;
                end else if (r_state == S_RUN) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_idx <= r_bit_idx + IDX_W'(1);
                end
            end
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + CNT_W'(1);
            end
        end
    end

    assign in_ready    = !r_hold_full;
    assign tx          = r_shift[0];
    assign bit_idx     = r_bit_idx;
    assign frame_count = r_frame_count;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench for spi_frame_tx: stimulus queues per-cycle expected line
// state, a negedge monitor pops and compares.
module tb_spi_frame_tx;

    logic        clk;
    logic        rst;
    logic        en;
    logic [10:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        tx;
    logic [3:0]  bit_idx;
    logic [5:0]  frame_count;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       tx;
        logic [3:0] bi;
        logic       und;
        logic [5:0] fc;
    } exp_t;

    exp_t q[$];

    spi_frame_tx #(.IDLE_WORD(11'h000)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx          (tx),
        .bit_idx     (bit_idx),
        .frame_count (frame_count),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry per cycle while the scoreboard holds any
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (tx !== e.tx || bit_idx !== e.bi || underrun !== e.und || frame_count !== e.fc) begin
                errors++;
                $display("FAIL line_state t=%0t got tx=%b bit_idx=%0d underrun=%b fc=%0d exp tx=%b bit_idx=%0d underrun=%b fc=%0d",
                         $time, tx, bit_idx, underrun, frame_count, e.tx, e.bi, e.und, e.fc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bits(input logic [10:0] word, input int n, input logic und, input logic [5:0] fc);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.tx  = word[k];
            e.bi  = 4'(k);
            e.und = (k == 0) ? und : 1'b0;
            e.fc  = fc;
            q.push_back(e);
        end
    endtask

    task automatic push_off(input int n, input logic [5:0] fc);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.tx  = 1'b0;
            e.bi  = 4'd0;
            e.und = 1'b0;
            e.fc  = fc;
            q.push_back(e);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b", name, got, exp);
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (tx !== 1'b0 || bit_idx !== 4'd0 || frame_count !== 6'd63 || in_ready !== 1'b1 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL %s got tx=%b bit_idx=%0d fc=%0d in_ready=%b underrun=%b exp 0/0/63/1/0",
                     name, tx, bit_idx, frame_count, in_ready, underrun);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d entries pending exp 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        in_data  = 11'h000;
        in_valid = 1'b0;

        // Reset values
        tick();
        tick();
        check_reset("reset_state");
        rst = 1'b0;

        // Word path 0x5A3 followed by two underrun frames; en dropped at bit 4 of third
        in_data  = 11'h5A3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check1("in_ready_after_push", in_ready, 1'b0);
        en = 1'b1;
        tick();
        push_bits(11'h5A3, 11, 1'b0, 6'd63);
        push_bits(11'h000, 11, 1'b1, 6'd0);
        push_bits(11'h000, 11, 1'b1, 6'd1);
        repeat (26) tick();
        check1("bit4_before_stop", (bit_idx == 4'd4), 1'b1);
        en = 1'b0;
        push_off(2, 6'd2);
        drain("drain_wordpath");

        // Back-to-back 0x7FF (bypass from OFF) then 0x001 via hold
        in_data  = 11'h7FF;
        in_valid = 1'b1;
        en       = 1'b1;
        tick();
        in_valid = 1'b0;
        check1("in_ready_after_bypass", in_ready, 1'b1);
        push_bits(11'h7FF, 11, 1'b0, 6'd2);
        in_data  = 11'h001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check1("in_ready_held", in_ready, 1'b0);
        push_bits(11'h001, 11, 1'b0, 6'd3);
        repeat (9) tick();
        check1("in_ready_before_load", in_ready, 1'b0);
        tick();
        check1("in_ready_after_load", in_ready, 1'b1);

        // Bypass handshake on the bit 10 edge
        repeat (10) tick();
        check1("at_bit10", (bit_idx == 4'd10), 1'b1);
        in_data  = 11'h400;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check1("hold_empty_after_bypass", in_ready, 1'b1);
        push_bits(11'h400, 11, 1'b0, 6'd4);
        en = 1'b0;
        push_off(2, 6'd5);
        drain("drain_b2b");

        // Reset mid-frame with a held word
        in_data  = 11'h123;
        in_valid = 1'b1;
        en       = 1'b1;
        tick();
        push_bits(11'h123, 6, 1'b0, 6'd5);
        in_data = 11'h2AA;
        tick();
        in_valid = 1'b0;
        check1("hold_full_before_reset", in_ready, 1'b0);
        repeat (5) tick();
        check1("at_bit6", (bit_idx == 4'd6), 1'b1);
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check_reset("async_reset_midframe");
        tick();
        check_reset("reset_held");
        rst = 1'b0;
        tick();
        check_reset("off_after_reset");

        // Held word was discarded: next frame is an idle fill
        en = 1'b1;
        tick();
        push_bits(11'h000, 11, 1'b1, 6'd63);
        en = 1'b0;
        push_off(2, 6'd0);
        drain("drain_post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
